// File: rtl/decoder_cu_if.sv
// Handshake and control bundle between the decoder control unit and the
// decoder datapath (round sub-blocks, state register, round-constant ROM).
interface decoder_cu_if #(
    parameter int RW = 5
);
    // start is a request level that the controller samples only while Ready is
    // high. Each *_done is a level or a pulse that is sampled only while the
    // controller sits in that stage's Calc state. A done outside its Calc
    // window is ignored. *_rst / *_start / load / Done are one-cycle strobes.
    logic          start;
    logic          irc_done;
    logic          irv_done;
    logic          ipr_done;
    logic          irt_done;
    logic          icp_done;

    logic          Ready;
    logic          sel;
    logic          load;
    logic [RW-1:0] round;
    logic          irc_rst;
    logic          irc_start;
    logic          irv_rst;
    logic          irv_start;
    logic          ipr_rst;
    logic          ipr_start;
    logic          irt_rst;
    logic          irt_start;
    logic          icp_rst;
    logic          icp_start;
    logic          Done;
    logic [4:0]    state_dbg;

    modport master (
        input  start, irc_done, irv_done, ipr_done, irt_done, icp_done,
        output Ready, sel, load, round,
        output irc_rst, irc_start, irv_rst, irv_start, ipr_rst, ipr_start,
        output irt_rst, irt_start, icp_rst, icp_start, Done, state_dbg
    );

    modport slave (
        output start, irc_done, irv_done, ipr_done, irt_done, icp_done,
        input  Ready, sel, load, round,
        input  irc_rst, irc_start, irv_rst, irv_start, ipr_rst, ipr_start,
        input  irt_rst, irt_start, icp_rst, icp_start, Done, state_dbg
    );
endinterface

// File: rtl/decoder_cu.sv
// Decoder control unit: Moore FSM that runs the inverse round stages
// (irc, irv, ipr, irt, icp) for ROUNDS rounds with a down-counting round index.
module decoder_cu #(
    parameter int ROUNDS = 24,
    parameter int RW     = 5
) (
    input  logic         clk,
    input  logic         reset,
    decoder_cu_if.master bus
);

    typedef enum logic [4:0] {
        IDLE        = 5'd0,
        GET_DATA    = 5'd1,
        INIT_RC     = 5'd2,
        BEG_RC      = 5'd3,
        CALC_RC     = 5'd4,
        INIT_RV     = 5'd5,
        BEG_RV      = 5'd6,
        CALC_RV     = 5'd7,
        INIT_PR     = 5'd8,
        BEG_PR      = 5'd9,
        CALC_PR     = 5'd10,
        INIT_RT     = 5'd11,
        BEG_RT      = 5'd12,
        CALC_RT     = 5'd13,
        INIT_CP     = 5'd14,
        BEG_CP      = 5'd15,
        CALC_CP     = 5'd16,
        FETCH_STATE = 5'd17,
        NEXT_ROUND  = 5'd18,
        FINISH      = 5'd19
    } state_e;

    localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);

    state_e        state_q;
    state_e        state_d;
    logic [RW-1:0] round_q;
    logic [RW-1:0] round_d;

    logic ready_o;
    logic sel_o;
    logic load_o;
    logic done_o;
    logic irc_rst_o, irc_start_o;
    logic irv_rst_o, irv_start_o;
    logic ipr_rst_o, ipr_start_o;
    logic irt_rst_o, irt_start_o;
    logic icp_rst_o, icp_start_o;

    // State register and round index.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
        end
    end

    // Next state; the round index only moves in GET_DATA and NEXT_ROUND.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        case (state_q)
            IDLE: begin
                if (bus.start) state_d = GET_DATA;
            end
            GET_DATA: begin
                round_d = LAST_ROUND;
                state_d = INIT_RC;
            end
            INIT_RC: state_d = BEG_RC;
            BEG_RC:  state_d = CALC_RC;
            CALC_RC: if (bus.irc_done) state_d = INIT_RV;
            INIT_RV: state_d = BEG_RV;
            BEG_RV:  state_d = CALC_RV;
            CALC_RV: if (bus.irv_done) state_d = INIT_PR;
            INIT_PR: state_d = BEG_PR;
            BEG_PR:  state_d = CALC_PR;
            CALC_PR: if (bus.ipr_done) state_d = INIT_RT;
            INIT_RT: state_d = BEG_RT;
            BEG_RT:  state_d = CALC_RT;
            CALC_RT: if (bus.irt_done) state_d = INIT_CP;
            INIT_CP: state_d = BEG_CP;
            BEG_CP:  state_d = CALC_CP;
            CALC_CP: if (bus.icp_done) state_d = FETCH_STATE;
            FETCH_STATE: begin
                state_d = (round_q == '0) ? FINISH : NEXT_ROUND;
            end
            NEXT_ROUND: begin
                // Guarded so the index can never wrap below zero.
                if (round_q != '0) round_d = round_q - RW'(1);
                state_d = INIT_RC;
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs, decoded from the present state only.
    always_comb begin
        ready_o     = 1'b0;
        sel_o       = 1'b0;
        load_o      = 1'b0;
        done_o      = 1'b0;
        irc_rst_o   = 1'b0;
        irc_start_o = 1'b0;
        irv_rst_o   = 1'b0;
        irv_start_o = 1'b0;
        ipr_rst_o   = 1'b0;
        ipr_start_o = 1'b0;
        irt_rst_o   = 1'b0;
        irt_start_o = 1'b0;
        icp_rst_o   = 1'b0;
        icp_start_o = 1'b0;
        case (state_q)
            IDLE:       ready_o = 1'b1;
            GET_DATA:   load_o  = 1'b1;
            INIT_RC:    irc_rst_o   = 1'b1;
            BEG_RC:     irc_start_o = 1'b1;
            INIT_RV:    irv_rst_o   = 1'b1;
            BEG_RV:     irv_start_o = 1'b1;
            INIT_PR:    ipr_rst_o   = 1'b1;
            BEG_PR:     ipr_start_o = 1'b1;
            INIT_RT:    irt_rst_o   = 1'b1;
            BEG_RT:     irt_start_o = 1'b1;
            INIT_CP:    icp_rst_o   = 1'b1;
            BEG_CP:     icp_start_o = 1'b1;
            NEXT_ROUND: begin
                sel_o  = 1'b1;
                load_o = 1'b1;
            end
            FINISH:     done_o = 1'b1;
            default:    ;
        endcase
    end

    assign bus.Ready     = ready_o;
    assign bus.sel       = sel_o;
    assign bus.load      = load_o;
    assign bus.round     = round_q;
    assign bus.Done      = done_o;
    assign bus.irc_rst   = irc_rst_o;
    assign bus.irc_start = irc_start_o;
    assign bus.irv_rst   = irv_rst_o;
    assign bus.irv_start = irv_start_o;
    assign bus.ipr_rst   = ipr_rst_o;
    assign bus.ipr_start = ipr_start_o;
    assign bus.irt_rst   = irt_rst_o;
    assign bus.irt_start = irt_start_o;
    assign bus.icp_rst   = icp_rst_o;
    assign bus.icp_start = icp_start_o;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_decoder_cu.sv
// Directed bench for decoder_cu: three instances (24, 2 and 1 rounds) sharing
// clock and reset, each scenario in its own task with hand-computed timing.
`timescale 1ns/1ps

`define OUTS(b) {b.Ready, b.sel, b.load, b.Done, b.irc_rst, b.irc_start, b.irv_rst, b.irv_start, b.ipr_rst, b.ipr_start, b.irt_rst, b.irt_start, b.icp_rst, b.icp_start}

module tb_decoder_cu;

  localparam logic [13:0] IDLE_OUTS = 14'b10_0000_0000_0000;

  // state_dbg codes the bench looks for
  localparam logic [4:0] S_IDLE    = 5'd0;
  localparam logic [4:0] S_GET     = 5'd1;
  localparam logic [4:0] S_CALC_RV = 5'd7;
  localparam logic [4:0] S_INIT_PR = 5'd8;
  localparam logic [4:0] S_CALC_PR = 5'd10;
  localparam logic [4:0] S_FETCH   = 5'd17;
  localparam logic [4:0] S_NEXT    = 5'd18;
  localparam logic [4:0] S_FINISH  = 5'd19;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  logic ipr_delay_en;
  int   ipr_cnt;

  decoder_cu_if #(.RW(5)) if24 ();
  decoder_cu_if #(.RW(5)) if2 ();
  decoder_cu_if #(.RW(5)) if1 ();

  decoder_cu #(.ROUNDS(24), .RW(5)) dut24 (.clk(clk), .reset(reset), .bus(if24));
  decoder_cu #(.ROUNDS(2),  .RW(5)) dut2  (.clk(clk), .reset(reset), .bus(if2));
  decoder_cu #(.ROUNDS(1),  .RW(5)) dut1  (.clk(clk), .reset(reset), .bus(if1));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ipr_done for the 2-round instance: immediate, or raised on the third
  // Calc_pr cycle when delay mode is on (two extra cycles per round).
  always @(negedge clk) begin
    if (!ipr_delay_en) begin
      if2.ipr_done = 1'b1;
    end else begin
      if (if2.ipr_start) ipr_cnt = 0;
      else ipr_cnt++;
      if2.ipr_done = (ipr_cnt == 3);
    end
  end

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    if24.start = 1'b1;
    if2.start  = 1'b1;
    if1.start  = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++;
      if (if24.state_dbg !== S_IDLE || if24.Ready !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_hold_%0d: state=%0d Ready=%b, required state=0 Ready=1", c, if24.state_dbg, if24.Ready);
      end
    end
    reset = 1'b0;
    if24.start = 1'b0;
    if2.start  = 1'b0;
    if1.start  = 1'b0;
    @(negedge clk);
    n_checks++;
    if (`OUTS(if24) !== IDLE_OUTS || if24.round !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_outs24: outs=%b round=%0d, required outs=%b round=0", `OUTS(if24), if24.round, IDLE_OUTS);
    end
    n_checks++;
    if (`OUTS(if2) !== IDLE_OUTS || if2.round !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_outs2: outs=%b round=%0d, required outs=%b round=0", `OUTS(if2), if2.round, IDLE_OUTS);
    end
    n_checks++;
    if (`OUTS(if1) !== IDLE_OUTS || if1.round !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_outs1: outs=%b round=%0d, required outs=%b round=0", `OUTS(if1), if1.round, IDLE_OUTS);
    end
  endtask

  task automatic test_full_decode();
    int done_cyc = -1;
    int n_done = 0;
    int loads0 = 0;
    int loads1 = 0;
    int sel_err = 0;
    int rc_idx = 0;
    int round_err = 0;
    int seq_idx = 0;
    int order_err = 0;
    int st_cnt[5];
    logic ready_after = 1'b0;
    logic [4:0] st;
    for (int k = 0; k < 5; k++) st_cnt[k] = 0;
    @(negedge clk);
    if24.start = 1'b1;
    for (int n = 1; n <= 415; n++) begin
      @(negedge clk);
      if (n == 1) if24.start = 1'b0;
      if (if24.load) begin
        if (if24.sel) loads1++;
        else begin
          loads0++;
          if (loads1 != 0) sel_err++;
        end
      end
      if (if24.irc_rst) begin
        if (if24.round !== 5'(23 - rc_idx)) round_err++;
        rc_idx++;
      end
      st = {if24.irc_start, if24.irv_start, if24.ipr_start, if24.irt_start, if24.icp_start};
      for (int k = 0; k < 5; k++) begin
        if (st[4-k]) begin
          st_cnt[k]++;
          if (k != seq_idx % 5) order_err++;
          seq_idx++;
        end
      end
      if (if24.Done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = n;
      end
      if (done_cyc > 0 && n == done_cyc + 1) ready_after = if24.Ready;
    end
    n_checks++;
    if (done_cyc != 409) begin
      n_fail++;
      $display("FAIL full_done_cycle: got %0d, required 409", done_cyc);
    end
    n_checks++;
    if (n_done != 1) begin
      n_fail++;
      $display("FAIL full_done_pulses: got %0d, required 1", n_done);
    end
    n_checks++;
    if (ready_after !== 1'b1) begin
      n_fail++;
      $display("FAIL full_ready_after: got %b, required 1", ready_after);
    end
    n_checks++;
    if (loads0 != 1 || loads1 != 23 || sel_err != 0) begin
      n_fail++;
      $display("FAIL full_loads: sel0=%0d sel1=%0d order_err=%0d, required 1 23 0", loads0, loads1, sel_err);
    end
    n_checks++;
    if (rc_idx != 24 || round_err != 0) begin
      n_fail++;
      $display("FAIL full_round_seq: rounds=%0d errors=%0d, required 24 0", rc_idx, round_err);
    end
    n_checks++;
    if (order_err != 0) begin
      n_fail++;
      $display("FAIL full_start_order: errors=%0d, required 0", order_err);
    end
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (st_cnt[k] != 24) begin
        n_fail++;
        $display("FAIL full_start_count_%0d: got %0d, required 24", k, st_cnt[k]);
      end
    end
  endtask

  task automatic test_delayed_done();
    int done_cyc = -1;
    int pr_cycles = 0;
    ipr_delay_en = 1'b1;
    ipr_cnt = 0;
    @(negedge clk);
    if2.start = 1'b1;
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      if (n == 1) if2.start = 1'b0;
      if (if2.state_dbg == S_CALC_PR) pr_cycles++;
      if (if2.Done && done_cyc < 0) done_cyc = n;
    end
    ipr_delay_en = 1'b0;
    n_checks++;
    if (done_cyc != 39) begin
      n_fail++;
      $display("FAIL delayed_done_cycle: got %0d, required 39", done_cyc);
    end
    // irt_done is held high throughout, so leaving Calc_pr early would show here
    n_checks++;
    if (pr_cycles != 6) begin
      n_fail++;
      $display("FAIL delayed_calc_pr_cycles: got %0d, required 6", pr_cycles);
    end
  endtask

  task automatic test_ignored_start();
    int done_cnt = 0;
    int done_cyc[2];
    done_cyc[0] = -1;
    done_cyc[1] = -1;
    @(negedge clk);
    if2.start = 1'b1;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (n == 1) if2.start = 1'b0;
      if (n == 7) begin
        n_checks++;
        if (if2.state_dbg !== S_CALC_RV) begin
          n_fail++;
          $display("FAIL ign_calc_rv: state=%0d, required %0d", if2.state_dbg, S_CALC_RV);
        end
        if2.start = 1'b1;
      end
      if (n == 8) begin
        n_checks++;
        if (if2.state_dbg !== S_INIT_PR || if2.round !== 5'd1) begin
          n_fail++;
          $display("FAIL ign_no_restart: state=%0d round=%0d, required %0d 1", if2.state_dbg, if2.round, S_INIT_PR);
        end
      end
      if (n == 36) begin
        n_checks++;
        if (if2.state_dbg !== S_IDLE || if2.Ready !== 1'b1) begin
          n_fail++;
          $display("FAIL ign_idle_gap: state=%0d Ready=%b, required 0 1", if2.state_dbg, if2.Ready);
        end
      end
      if (n == 37) begin
        n_checks++;
        if (if2.state_dbg !== S_GET || if2.Ready !== 1'b0 || if2.load !== 1'b1 || if2.sel !== 1'b0) begin
          n_fail++;
          $display("FAIL ign_restart: state=%0d Ready=%b load=%b sel=%b, required 1 0 1 0", if2.state_dbg, if2.Ready, if2.load, if2.sel);
        end
        if2.start = 1'b0;
      end
      if (if2.Done) begin
        if (done_cnt < 2) done_cyc[done_cnt] = n;
        done_cnt++;
      end
    end
    n_checks++;
    if (done_cnt != 2 || done_cyc[0] != 35 || done_cyc[1] != 71) begin
      n_fail++;
      $display("FAIL ign_done_cycles: count=%0d first=%0d second=%0d, required 2 35 71", done_cnt, done_cyc[0], done_cyc[1]);
    end
  endtask

  task automatic test_mid_reset();
    int n_done = 0;
    int done_cyc = -1;
    @(negedge clk);
    if24.start = 1'b1;
    for (int n = 1; n <= 231; n++) begin
      @(negedge clk);
      if (n == 1) if24.start = 1'b0;
      if (if24.Done) n_done++;
    end
    n_checks++;
    if (if24.state_dbg !== S_CALC_PR || if24.round !== 5'd10) begin
      n_fail++;
      $display("FAIL mid_reach_calc_pr: state=%0d round=%0d, required %0d 10", if24.state_dbg, if24.round, S_CALC_PR);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (`OUTS(if24) !== IDLE_OUTS || if24.round !== 5'd0 || if24.state_dbg !== S_IDLE) begin
      n_fail++;
      $display("FAIL mid_reset_idle: outs=%b round=%0d state=%0d, required %b 0 0", `OUTS(if24), if24.round, if24.state_dbg, IDLE_OUTS);
    end
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (if24.Done || !if24.Ready) n_done++;
    end
    n_checks++;
    if (n_done != 0) begin
      n_fail++;
      $display("FAIL mid_no_done: stray events=%0d, required 0", n_done);
    end
    @(negedge clk);
    if24.start = 1'b1;
    for (int n = 1; n <= 412; n++) begin
      @(negedge clk);
      if (n == 1) if24.start = 1'b0;
      if (if24.Done && done_cyc < 0) done_cyc = n;
    end
    n_checks++;
    if (done_cyc != 409) begin
      n_fail++;
      $display("FAIL mid_redecode_done: got %0d, required 409", done_cyc);
    end
  endtask

  task automatic test_single_round();
    int done_cyc = -1;
    int loads0 = 0;
    int loads1 = 0;
    int next_seen = 0;
    @(negedge clk);
    if1.start = 1'b1;
    for (int n = 1; n <= 25; n++) begin
      @(negedge clk);
      if (n == 1) if1.start = 1'b0;
      if (n == 17) begin
        n_checks++;
        if (if1.state_dbg !== S_FETCH || if1.round !== 5'd0) begin
          n_fail++;
          $display("FAIL single_fetch: state=%0d round=%0d, required %0d 0", if1.state_dbg, if1.round, S_FETCH);
        end
      end
      if (n == 18) begin
        n_checks++;
        if (if1.state_dbg !== S_FINISH) begin
          n_fail++;
          $display("FAIL single_finish: state=%0d, required %0d", if1.state_dbg, S_FINISH);
        end
      end
      if (if1.state_dbg == S_NEXT) next_seen++;
      if (if1.load) begin
        if (if1.sel) loads1++;
        else loads0++;
      end
      if (if1.Done && done_cyc < 0) done_cyc = n;
    end
    n_checks++;
    if (done_cyc != 18) begin
      n_fail++;
      $display("FAIL single_done_cycle: got %0d, required 18", done_cyc);
    end
    n_checks++;
    if (loads0 != 1 || loads1 != 0 || next_seen != 0) begin
      n_fail++;
      $display("FAIL single_loads: sel0=%0d sel1=%0d next_round=%0d, required 1 0 0", loads0, loads1, next_seen);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_checks = 0;
    n_fail = 0;
    ipr_delay_en = 1'b0;
    ipr_cnt = 0;
    reset = 1'b0;
    if24.start = 1'b0;
    if24.irc_done = 1'b1;
    if24.irv_done = 1'b1;
    if24.ipr_done = 1'b1;
    if24.irt_done = 1'b1;
    if24.icp_done = 1'b1;
    if2.start = 1'b0;
    if2.irc_done = 1'b1;
    if2.irv_done = 1'b1;
    if2.irt_done = 1'b1;
    if2.icp_done = 1'b1;
    if1.start = 1'b0;
    if1.irc_done = 1'b1;
    if1.irv_done = 1'b1;
    if1.ipr_done = 1'b1;
    if1.irt_done = 1'b1;
    if1.icp_done = 1'b1;

    test_reset();
    test_full_decode();
    test_delayed_done();
    test_ignored_start();
    test_mid_reset();
    test_single_round();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
